// File: rtl/pattern_seq_detector.sv
// Programmable multi-symbol sequence detector on an enable-qualified stream.
// Per-bit don't-care mask, optional overlapping matches, saturating match counter.
module pattern_seq_detector #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3,
    parameter int CNT_W = 8,
    parameter logic [WIDTH*DEPTH-1:0] RESET_PATTERN = {DEPTH{4'b1000}},
    parameter logic [WIDTH*DEPTH-1:0] RESET_MASK = '1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   cfg_we,
    input  logic [WIDTH*DEPTH-1:0] cfg_pattern,
    input  logic [WIDTH*DEPTH-1:0] cfg_mask,
    input  logic                   overlap_en,
    output logic                   match_pulse,
    output logic [CNT_W-1:0]       match_count,
    output logic                   count_sat
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    logic [WIDTH*DEPTH-1:0]     history;
    logic [WIDTH*DEPTH-1:0]     pattern;
    logic [WIDTH*DEPTH-1:0]     mask;
    logic [FW-1:0]              fill;
    logic [WIDTH*(DEPTH+1)-1:0] cand_ext;
    logic [WIDTH*DEPTH-1:0]     cand;
    logic [CNT_W-1:0]           cnt_inc;
    logic                       hit;

    // Shifting through a widened vector keeps DEPTH=1 legal (oldest slice falls off the top).
    always_comb begin
        cand_ext = {history, data_in};
        cand     = cand_ext[WIDTH*DEPTH-1:0];
        cnt_inc  = match_count + CNT_W'(1);
        hit      = enable && ((int'(fill) + 1) >= DEPTH) && (((cand ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            history     <= '0;
            fill        <= '0;
            pattern     <= RESET_PATTERN;
            mask        <= RESET_MASK;
            match_pulse <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            if (clear) begin
                history     <= '0;
                fill        <= '0;
                match_count <= '0;
                count_sat   <= 1'b0;
            end else if (cfg_we) begin
                pattern <= cfg_pattern;
                mask    <= cfg_mask;
                fill    <= '0;
            end else if (enable) begin
                history <= cand;
                if (hit && !overlap_en) begin
                    fill <= '0;
                end else if (fill != FULL) begin
                    fill <= fill + 1'b1;
                end
                if (hit) begin
                    match_pulse <= 1'b1;
                    if (match_count != '1) begin
                        match_count <= cnt_inc;
                        if (cnt_inc == '1) begin
                            count_sat <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed bench for pattern_seq_detector: default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_pattern_seq_detector;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        enable;
    logic [3:0]  data_in;
    logic        cfg_we;
    logic [11:0] cfg_pattern;
    logic [11:0] cfg_mask;
    logic        overlap_en;
    logic        pulse_a, sat_a, pulse_b, sat_b;
    logic [7:0]  count_a;
    logic [1:0]  count_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pattern_seq_detector dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .data_in(data_in),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .overlap_en(overlap_en), .match_pulse(pulse_a), .match_count(count_a),
        .count_sat(sat_a)
    );

    pattern_seq_detector #(.CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .data_in(data_in),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .overlap_en(overlap_en), .match_pulse(pulse_b), .match_count(count_b),
        .count_sat(sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] s);
        enable  = 1'b1;
        data_in = s;
        tick();
        enable  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic cfg(input logic [11:0] pat, input logic [11:0] msk);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_mask    = msk;
        tick();
        cfg_we      = 1'b0;
    endtask

    // Push five symbols and compare dut_a's pulse after each against an expected bit string.
    task automatic run5(input string tag, input logic [19:0] syms, input logic [4:0] exp_p);
        for (int i = 0; i < 5; i++) begin
            push(syms[19-4*i -: 4]);
            chk($sformatf("%s_p%0d", tag, i), 32'(pulse_a), 32'(exp_p[4-i]));
        end
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; enable = 1'b0; data_in = '0;
        cfg_we = 1'b0; cfg_pattern = '0; cfg_mask = '0; overlap_en = 1'b1;
        #1;
        chk("rst_pulse", 32'(pulse_a), 32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_sat",   32'(sat_a),   32'd0);
        #11 reset_n = 1'b1;

        // overlapping: A,B,A,B,A -> pulses after 3rd and 5th accept
        cfg(12'hABA, 12'hFFF);
        overlap_en = 1'b1;
        do_clear();
        run5("ovl", 20'hABABA, 5'b00101);
        chk("ovl_count", 32'(count_a), 32'd2);

        do_clear();
        chk("clr_count", 32'(count_a), 32'd0);

        // non-overlapping: same stream -> single pulse
        overlap_en = 1'b0;
        run5("novl", 20'hABABA, 5'b00100);
        chk("novl_count", 32'(count_a), 32'd1);

        // gap of 3 idle cycles does not break the sequence
        overlap_en = 1'b1;
        do_clear();
        push(4'hA);
        chk("gap_a", 32'(pulse_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("gap_idle%0d", i), 32'(pulse_a), 32'd0);
        end
        push(4'hB);
        chk("gap_b", 32'(pulse_a), 32'd0);
        push(4'hA);
        chk("gap_hit", 32'(pulse_a), 32'd1);
        chk("gap_count", 32'(count_a), 32'd1);

        // mask FF0: newest symbol is don't-care
        cfg(12'hABA, 12'hFF0);
        do_clear();
        push(4'hA); push(4'hB); push(4'h7);
        chk("mask_hit", 32'(pulse_a), 32'd1);
        do_clear();
        push(4'hA); push(4'hC); push(4'hA);
        chk("mask_miss", 32'(pulse_a), 32'd0);

        // all-zero mask: any full history matches
        cfg(12'h000, 12'h000);
        do_clear();
        push(4'h3); chk("m0_p0", 32'(pulse_a), 32'd0);
        push(4'h9); chk("m0_p1", 32'(pulse_a), 32'd0);
        push(4'hE); chk("m0_p2", 32'(pulse_a), 32'd1);

        // CNT_W=2 saturation on dut_b: six 1s, overlapping
        cfg(12'h111, 12'hFFF);
        overlap_en = 1'b1;
        do_clear();
        begin
            logic [5:0]  exp_p;
            logic [11:0] exp_c;
            logic [5:0]  exp_s;
            exp_p = 6'b001111;
            exp_c = {2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
            exp_s = 6'b000011;
            for (int i = 0; i < 6; i++) begin
                push(4'h1);
                chk($sformatf("sat_p%0d", i), 32'(pulse_b), 32'(exp_p[5-i]));
                chk($sformatf("sat_c%0d", i), 32'(count_b), 32'(exp_c[11-2*i -: 2]));
                chk($sformatf("sat_s%0d", i), 32'(sat_b),   32'(exp_s[5-i]));
            end
        end

        // cfg_we flushes fill and drops that cycle's symbol
        cfg(12'hABA, 12'hFFF);
        do_clear();
        push(4'hA); push(4'hB);
        cfg_we = 1'b1; enable = 1'b1; data_in = 4'hA;
        tick();
        cfg_we = 1'b0; enable = 1'b0;
        chk("cfg_drop", 32'(pulse_a), 32'd0);
        push(4'hA); chk("cfg_flush", 32'(pulse_a), 32'd0);
        push(4'hB); chk("cfg_b",     32'(pulse_a), 32'd0);
        push(4'hA); chk("cfg_hit",   32'(pulse_a), 32'd1);

        // asynchronous reset mid-sequence
        do_clear();
        push(4'hA); push(4'hB); push(4'hA);
        chk("pre_rst_count", 32'(count_a), 32'd1);
        push(4'hA); push(4'hB);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(count_a), 32'd0);
        chk("arst_pulse", 32'(pulse_a), 32'd0);
        #2 reset_n = 1'b1;
        push(4'hA); chk("post_rst_a", 32'(pulse_a), 32'd0);
        push(4'h8); chk("post_rst_8a", 32'(pulse_a), 32'd0);
        push(4'h8); chk("post_rst_8b", 32'(pulse_a), 32'd0);
        push(4'h8); chk("rst_pattern", 32'(pulse_a), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
